// File: rtl/ysyx_22041071_hazard_ctrl_pkg.sv
// Shared codes for the hazard controller: forwarding selects, FSM states,
// shadow-stage flags and the ALU_ctrl muldiv range.
package ysyx_22041071_hazard_ctrl_pkg;

  localparam int unsigned FWD_W   = 2;
  localparam int unsigned WDOG_CW = 8;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'd0;
  localparam logic [FWD_W-1:0] FWD_EX  = 2'd1;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'd2;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'd3;

  localparam int unsigned ALU_MULDIV_LO = 19;
  localparam int unsigned ALU_MULDIV_HI = 30;

  typedef enum logic {
    HZ_RUN  = 1'b0,
    HZ_BUSY = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic valid;
    logic wen;
    logic load;
  } stage_flags_t;

endpackage

// File: rtl/ysyx_22041071_hazard_ctrl_if.sv
// Decode-side hazard bundle: ID fields and pipeline events in, stall/flush/forward out.
interface ysyx_22041071_hazard_ctrl_if #(
  parameter int unsigned RF_AW = 5
);
  logic             id_valid;
  logic [RF_AW-1:0] id_rs1;
  logic [RF_AW-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [RF_AW-1:0] id_rd;
  logic             id_reg_w_en;
  logic             id_is_load;
  logic             id_is_muldiv;
  logic             ex_done;
  logic             redirect;
  logic             stall;
  logic             flush_id;
  logic [1:0]       fwd1_sel;
  logic [1:0]       fwd2_sel;
  logic             muldiv_busy;
  logic             muldiv_err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_w_en, id_is_load, id_is_muldiv, ex_done, redirect,
    input  stall, flush_id, fwd1_sel, fwd2_sel, muldiv_busy, muldiv_err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_w_en, id_is_load, id_is_muldiv, ex_done, redirect,
    output stall, flush_id, fwd1_sel, fwd2_sel, muldiv_busy, muldiv_err
  );
endinterface

// File: rtl/ysyx_22041071_fwd_mux_sel.sv
// Per-source forwarding priority matcher (EX > MEM > WB); also flags an EX hit
// so the parent can detect load-use.
module ysyx_22041071_fwd_mux_sel
  import ysyx_22041071_hazard_ctrl_pkg::*;
#(
  parameter int unsigned RF_AW = 5
) (
  input  logic [RF_AW-1:0] rs_i,
  input  logic             use_i,
  input  logic             ex_prod_i,
  input  logic [RF_AW-1:0] ex_rd_i,
  input  logic             mem_prod_i,
  input  logic [RF_AW-1:0] mem_rd_i,
  input  logic             wb_prod_i,
  input  logic [RF_AW-1:0] wb_rd_i,
  output logic [FWD_W-1:0] sel_o,
  output logic             ex_hit_o
);

  always_comb begin
    sel_o    = FWD_RF;
    ex_hit_o = 1'b0;
    if (use_i && (rs_i != '0)) begin
      if (ex_prod_i && (ex_rd_i == rs_i)) begin
        sel_o    = FWD_EX;
        ex_hit_o = 1'b1;
      end else if (mem_prod_i && (mem_rd_i == rs_i)) begin
        sel_o = FWD_MEM;
      end else if (wb_prod_i && (wb_rd_i == rs_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/ysyx_22041071_hazard_ctrl.sv
// Hazard controller: shadow scoreboard of EX/MEM/WB destinations driving
// forwarding selects, load-use and muldiv stalls, and redirect flushes.
module ysyx_22041071_hazard_ctrl
  import ysyx_22041071_hazard_ctrl_pkg::*;
#(
  parameter int unsigned RF_AW    = 5,
  parameter int unsigned WDOG_MAX = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  ysyx_22041071_hazard_ctrl_if.slave    hz
);

  stage_flags_t       ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [RF_AW-1:0]   ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  hz_state_e          state_q, state_d;
  logic [WDOG_CW-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               ex_prod, mem_prod, wb_prod;
  logic               ex_hit1, ex_hit2;
  logic [FWD_W-1:0]   sel1, sel2;
  logic               load_use_c, stall_c, flush_c, take_c;

  assign ex_prod  = ex_q.valid  & ex_q.wen  & (ex_rd_q  != '0);
  assign mem_prod = mem_q.valid & mem_q.wen & (mem_rd_q != '0);
  assign wb_prod  = wb_q.valid  & wb_q.wen  & (wb_rd_q  != '0);

  ysyx_22041071_fwd_mux_sel #(.RF_AW(RF_AW)) u_fwd1 (
    .rs_i      (hz.id_rs1),
    .use_i     (hz.id_use_rs1),
    .ex_prod_i (ex_prod),
    .ex_rd_i   (ex_rd_q),
    .mem_prod_i(mem_prod),
    .mem_rd_i  (mem_rd_q),
    .wb_prod_i (wb_prod),
    .wb_rd_i   (wb_rd_q),
    .sel_o     (sel1),
    .ex_hit_o  (ex_hit1)
  );

  ysyx_22041071_fwd_mux_sel #(.RF_AW(RF_AW)) u_fwd2 (
    .rs_i      (hz.id_rs2),
    .use_i     (hz.id_use_rs2),
    .ex_prod_i (ex_prod),
    .ex_rd_i   (ex_rd_q),
    .mem_prod_i(mem_prod),
    .mem_rd_i  (mem_rd_q),
    .wb_prod_i (wb_prod),
    .wb_rd_i   (wb_rd_q),
    .sel_o     (sel2),
    .ex_hit_o  (ex_hit2)
  );

  // ex_hit already implies the EX entry is a producer matching a used, nonzero source
  assign load_use_c = hz.id_valid & ex_q.load & (ex_hit1 | ex_hit2);

  // Next-state and decision logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    wb_d     = mem_q;
    wb_rd_d  = mem_rd_q;
    mem_d    = ex_q;
    mem_rd_d = ex_rd_q;
    ex_d     = '0;
    ex_rd_d  = '0;
    stall_c  = 1'b0;
    flush_c  = hz.redirect;
    take_c   = 1'b0;

    case (state_q)
      HZ_RUN: begin
        stall_c = load_use_c & ~hz.redirect;
        take_c  = hz.id_valid & ~hz.redirect & ~load_use_c;
      end
      HZ_BUSY: begin
        if (cnt_q != '1) cnt_d = cnt_q + WDOG_CW'(1);
        if (cnt_d == WDOG_CW'(WDOG_MAX)) err_d = 1'b1;
        if (hz.ex_done) begin
          state_d = HZ_RUN;
          take_c  = hz.id_valid & ~hz.redirect;
        end else begin
          // muldiv parked in EX; older stages drain behind it
          stall_c  = 1'b1;
          ex_d     = ex_q;
          ex_rd_d  = ex_rd_q;
          mem_d    = '0;
          mem_rd_d = '0;
        end
      end
      default: state_d = HZ_RUN;
    endcase

    if (take_c) begin
      ex_d.valid = 1'b1;
      ex_d.wen   = hz.id_reg_w_en;
      ex_d.load  = hz.id_is_load;
      ex_rd_d    = hz.id_rd;
      if (hz.id_is_muldiv) begin
        state_d = HZ_BUSY;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      ex_rd_q  <= '0;
      mem_rd_q <= '0;
      wb_rd_q  <= '0;
      state_q  <= HZ_RUN;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      ex_rd_q  <= ex_rd_d;
      mem_rd_q <= mem_rd_d;
      wb_rd_q  <= wb_rd_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign hz.stall       = stall_c;
  assign hz.flush_id    = flush_c;
  assign hz.fwd1_sel    = sel1;
  assign hz.fwd2_sel    = sel2;
  assign hz.muldiv_busy = (state_q == HZ_BUSY);
  assign hz.muldiv_err  = err_q;

endmodule

// File: tb/tb_ysyx_22041071_hazard_ctrl.sv
// Self-checking bench for the hazard controller: directed scenarios plus
// randomized traffic against a shift-register pipeline model.
module tb_ysyx_22041071_hazard_ctrl;

  localparam int unsigned WDOG = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ysyx_22041071_hazard_ctrl_if #(.RF_AW(5)) hz ();

  ysyx_22041071_hazard_ctrl #(.RF_AW(5), .WDOG_MAX(WDOG)) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       w;
    logic       l;
  } ent_t;

  ent_t pipe [3];
  bit   m_busy;
  bit   m_err;
  int   m_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input bit [4:0] rs1, input bit u1,
                        input bit [4:0] rs2, input bit u2, input bit [4:0] rd,
                        input bit w, input bit l, input bit m);
    hz.id_valid     = v;
    hz.id_rs1       = rs1;
    hz.id_use_rs1   = u1;
    hz.id_rs2       = rs2;
    hz.id_use_rs2   = u2;
    hz.id_rd        = rd;
    hz.id_reg_w_en  = w;
    hz.id_is_load   = l;
    hz.id_is_muldiv = m;
  endtask

  task automatic clear_in();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    hz.ex_done  = 1'b0;
    hz.redirect = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic bit prod(input int k);
    return pipe[k].v && pipe[k].w && (pipe[k].rd != 5'd0);
  endfunction

  function automatic logic [1:0] m_fwd(input bit [4:0] rs, input bit u);
    if (!u || rs == 5'd0) return 2'd0;
    for (int k = 0; k < 3; k++)
      if (prod(k) && pipe[k].rd == rs) return 2'(k + 1);
    return 2'd0;
  endfunction

  task automatic test_reset();
    clear_in();
    reset = 1'b1;
    tick();
    n_vec++;
    if ({hz.stall, hz.flush_id, hz.muldiv_busy, hz.muldiv_err, hz.fwd1_sel, hz.fwd2_sel} !== 8'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b required 00000000",
               {hz.stall, hz.flush_id, hz.muldiv_busy, hz.muldiv_err, hz.fwd1_sel, hz.fwd2_sel});
    end
    reset = 1'b0;
    set_id(1, 5, 1, 6, 1, 7, 1, 0, 0);
    #1;
    n_vec++;
    if (hz.fwd1_sel !== 2'd0 || hz.fwd2_sel !== 2'd0 || hz.stall !== 1'b0) begin
      n_err++;
      $display("FAIL reset_empty_shadow: fwd1=%0d fwd2=%0d stall=%b required 0 0 0",
               hz.fwd1_sel, hz.fwd2_sel, hz.stall);
    end
  endtask

  task automatic test_fwd_ex();
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 0, 0);          // addi x5
    tick();
    set_id(1, 5, 1, 5, 1, 6, 1, 0, 0);          // add x6,x5,x5
    #1;
    n_vec++;
    if (hz.fwd1_sel !== 2'd1 || hz.fwd2_sel !== 2'd1 || hz.stall !== 1'b0) begin
      n_err++;
      $display("FAIL fwd_ex: fwd1=%0d fwd2=%0d stall=%b required 1 1 0", hz.fwd1_sel, hz.fwd2_sel, hz.stall);
    end
    tick();
    set_id(1, 5, 1, 6, 1, 10, 1, 0, 0);         // x5 in MEM, x6 in EX
    #1;
    n_vec++;
    if (hz.fwd1_sel !== 2'd2 || hz.fwd2_sel !== 2'd1) begin
      n_err++;
      $display("FAIL fwd_mem_ex: fwd1=%0d fwd2=%0d required 2 1", hz.fwd1_sel, hz.fwd2_sel);
    end
    tick();
    set_id(1, 5, 1, 6, 1, 11, 1, 0, 0);         // x5 in WB, x6 in MEM
    #1;
    n_vec++;
    if (hz.fwd1_sel !== 2'd3 || hz.fwd2_sel !== 2'd2) begin
      n_err++;
      $display("FAIL fwd_wb_mem: fwd1=%0d fwd2=%0d required 3 2", hz.fwd1_sel, hz.fwd2_sel);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 0, 0, 0, 0, 7, 1, 1, 0);          // ld x7
    tick();
    set_id(1, 7, 1, 0, 1, 8, 1, 0, 0);          // add x8,x7,x0
    #1;
    n_vec++;
    if (hz.stall !== 1'b1 || hz.flush_id !== 1'b0) begin
      n_err++;
      $display("FAIL load_use_stall: stall=%b flush=%b required 1 0", hz.stall, hz.flush_id);
    end
    tick();
    n_vec++;
    if (hz.stall !== 1'b0 || hz.fwd1_sel !== 2'd2 || hz.fwd2_sel !== 2'd0) begin
      n_err++;
      $display("FAIL load_use_release: stall=%b fwd1=%0d fwd2=%0d required 0 2 0",
               hz.stall, hz.fwd1_sel, hz.fwd2_sel);
    end
  endtask

  task automatic test_muldiv();
    do_reset();
    set_id(1, 0, 0, 0, 0, 9, 1, 0, 1);          // mul x9
    tick();
    set_id(1, 9, 1, 0, 0, 10, 1, 0, 0);         // dependent add
    for (int i = 1; i <= 5; i++) begin
      hz.ex_done = (i == 5);
      #1;
      n_vec++;
      if (hz.muldiv_busy !== 1'b1 || hz.stall !== (i != 5)) begin
        n_err++;
        $display("FAIL muldiv_cycle%0d: busy=%b stall=%b required 1 %b", i, hz.muldiv_busy, hz.stall, i != 5);
      end
      tick();
      if (i == 5) begin end
    end
    hz.ex_done = 1'b0;
    set_id(1, 9, 1, 10, 1, 12, 1, 0, 0);
    #1;
    n_vec++;
    if (hz.muldiv_busy !== 1'b0 || hz.stall !== 1'b0 || hz.fwd1_sel !== 2'd2 || hz.fwd2_sel !== 2'd1) begin
      n_err++;
      $display("FAIL muldiv_after: busy=%b stall=%b fwd1=%0d fwd2=%0d required 0 0 2 1",
               hz.muldiv_busy, hz.stall, hz.fwd1_sel, hz.fwd2_sel);
    end
  endtask

  task automatic test_muldiv_release_fwd();
    do_reset();
    set_id(1, 0, 0, 0, 0, 9, 1, 0, 1);
    tick();
    set_id(1, 9, 1, 0, 0, 10, 1, 0, 0);
    tick();
    tick();
    hz.ex_done = 1'b1;
    #1;
    n_vec++;
    if (hz.fwd1_sel !== 2'd1 || hz.stall !== 1'b0) begin
      n_err++;
      $display("FAIL muldiv_release_fwd: fwd1=%0d stall=%b required 1 0", hz.fwd1_sel, hz.stall);
    end
    tick();
    hz.ex_done = 1'b0;
  endtask

  task automatic test_redirect_loaduse();
    do_reset();
    set_id(1, 0, 0, 0, 0, 7, 1, 1, 0);          // ld x7
    tick();
    set_id(1, 7, 1, 0, 0, 8, 1, 0, 0);
    hz.redirect = 1'b1;
    #1;
    n_vec++;
    if (hz.flush_id !== 1'b1 || hz.stall !== 1'b0) begin
      n_err++;
      $display("FAIL redirect_wins: flush=%b stall=%b required 1 0", hz.flush_id, hz.stall);
    end
    tick();
    hz.redirect = 1'b0;
    set_id(1, 7, 1, 8, 1, 9, 1, 0, 0);          // x8 was squashed, ld now in MEM
    #1;
    n_vec++;
    if (hz.fwd1_sel !== 2'd2 || hz.fwd2_sel !== 2'd0 || hz.stall !== 1'b0 || hz.flush_id !== 1'b0) begin
      n_err++;
      $display("FAIL redirect_bubble: fwd1=%0d fwd2=%0d stall=%b flush=%b required 2 0 0 0",
               hz.fwd1_sel, hz.fwd2_sel, hz.stall, hz.flush_id);
    end
  endtask

  task automatic test_x0();
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 1, 1, 0);          // ld x0
    tick();
    set_id(1, 0, 1, 0, 1, 3, 1, 0, 0);          // read x0
    #1;
    n_vec++;
    if (hz.fwd1_sel !== 2'd0 || hz.fwd2_sel !== 2'd0 || hz.stall !== 1'b0) begin
      n_err++;
      $display("FAIL x0_no_fwd: fwd1=%0d fwd2=%0d stall=%b required 0 0 0", hz.fwd1_sel, hz.fwd2_sel, hz.stall);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    set_id(1, 0, 0, 0, 0, 9, 1, 0, 1);
    tick();
    clear_in();
    for (int i = 1; i <= int'(WDOG); i++) begin
      tick();
      if (i == int'(WDOG) - 1) begin
        n_vec++;
        if (hz.muldiv_err !== 1'b0) begin
          n_err++;
          $display("FAIL wdog_early: err=%b required 0 after %0d busy cycles", hz.muldiv_err, i);
        end
      end
    end
    n_vec++;
    if (hz.muldiv_err !== 1'b1 || hz.muldiv_busy !== 1'b1 || hz.stall !== 1'b1) begin
      n_err++;
      $display("FAIL wdog_set: err=%b busy=%b stall=%b required 1 1 1", hz.muldiv_err, hz.muldiv_busy, hz.stall);
    end
    repeat (3) tick();
    n_vec++;
    if (hz.muldiv_err !== 1'b1) begin
      n_err++;
      $display("FAIL wdog_sticky: err=%b required 1", hz.muldiv_err);
    end
    reset = 1'b1;
    tick();
    n_vec++;
    if ({hz.stall, hz.flush_id, hz.muldiv_busy, hz.muldiv_err, hz.fwd1_sel, hz.fwd2_sel} !== 8'd0) begin
      n_err++;
      $display("FAIL wdog_reset: got %b required 00000000",
               {hz.stall, hz.flush_id, hz.muldiv_busy, hz.muldiv_err, hz.fwd1_sel, hz.fwd2_sel});
    end
    reset = 1'b0;
    tick();
    n_vec++;
    if (hz.muldiv_busy !== 1'b0 || hz.muldiv_err !== 1'b0 || hz.stall !== 1'b0) begin
      n_err++;
      $display("FAIL wdog_post_reset: busy=%b err=%b stall=%b required 0 0 0",
               hz.muldiv_busy, hz.muldiv_err, hz.stall);
    end
  endtask

  task automatic test_random(input int n);
    bit         lu, e_stall, e_flush, take;
    logic [1:0] e1, e2;
    int         kind;
    do_reset();
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    m_busy = 0;
    m_err  = 0;
    m_cnt  = 0;
    for (int c = 0; c < n; c++) begin
      kind = int'($urandom_range(3));
      set_id(1'($urandom_range(3) != 0), 5'($urandom_range(7)), 1'($urandom_range(1)),
             5'($urandom_range(7)), 1'($urandom_range(1)), 5'($urandom_range(7)),
             kind != 3, kind == 1, kind == 2);
      hz.redirect = !m_busy && ($urandom_range(7) == 0);
      hz.ex_done  = ($urandom_range(2) == 0);
      #1;
      e1 = m_fwd(hz.id_rs1, hz.id_use_rs1);
      e2 = m_fwd(hz.id_rs2, hz.id_use_rs2);
      lu = hz.id_valid && prod(0) && pipe[0].l && (e1 == 2'd1 || e2 == 2'd1);
      e_flush = hz.redirect;
      e_stall = m_busy ? !hz.ex_done : (lu && !hz.redirect);
      n_vec++;
      if (hz.stall !== e_stall || hz.flush_id !== e_flush || hz.fwd1_sel !== e1 || hz.fwd2_sel !== e2
          || hz.muldiv_busy !== m_busy || hz.muldiv_err !== m_err) begin
        n_err++;
        $display("FAIL rand_cycle%0d: stall/flush/f1/f2/busy/err=%b/%b/%0d/%0d/%b/%b required %b/%b/%0d/%0d/%b/%b",
                 c, hz.stall, hz.flush_id, hz.fwd1_sel, hz.fwd2_sel, hz.muldiv_busy, hz.muldiv_err,
                 e_stall, e_flush, e1, e2, m_busy, m_err);
      end
      if (m_busy) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt >= int'(WDOG)) m_err = 1;
      end
      if (m_busy && !hz.ex_done) begin
        pipe[2] = pipe[1];
        pipe[1] = '0;
      end else begin
        take    = hz.id_valid && !hz.redirect && !e_stall;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = take ? ent_t'{v: 1'b1, rd: hz.id_rd, w: hz.id_reg_w_en, l: hz.id_is_load} : '0;
        m_busy  = take && hz.id_is_muldiv;
        if (m_busy) m_cnt = 0;
      end
      tick();
    end
    clear_in();
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    tick();
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_muldiv();
    test_muldiv_release_fwd();
    test_redirect_loaduse();
    test_x0();
    test_watchdog();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
